// File: rtl/axis_pos_ctrl_if.sv
// Target handshake bundle for axis_pos_ctrl.
// The master offers a target position and the controller (slave) accepts it with tgt_ready.
interface axis_pos_ctrl_if #(
  parameter int POS_W = 24
);
  logic [POS_W-1:0] tgt_pos;
  logic             tgt_valid;
  logic             tgt_ready;

  modport master (
    output tgt_pos,
    output tgt_valid,
    input  tgt_ready
  );

  modport slave (
    input  tgt_pos,
    input  tgt_valid,
    output tgt_ready
  );
endinterface

// File: rtl/axis_pos_ctrl.sv
// Single-axis closed-loop position controller: integrates feedback pulses into a position,
// drives active-low enable / direction toward an accepted target and reports completion.
module axis_pos_ctrl #(
  parameter int POS_W      = 24,
  parameter int CNT_W      = 21,
  parameter int STEP_FWD   = 256,
  parameter int STEP_REV   = 256,
  parameter int TOL        = 3840,
  parameter int EC1        = 786432,
  parameter int EC2        = 524288,
  parameter int EC3        = 262144,
  parameter int EC4        = 65536,
  parameter int PL0        = 250000,
  parameter int PL1        = 200000,
  parameter int PL2        = 150000,
  parameter int PL3        = 100000,
  parameter int PL4        = 50000,
  parameter int SETTLE_CYC = 1024
) (
  input  logic             clk_50m_i,
  input  logic             rst_ni,
  input  logic             pulse_i,
  input  logic             abort_i,
  input  logic             zero_pos_i,
  axis_pos_ctrl_if.slave   tgt_if,
  output logic             en_o,
  output logic             dirc_o,
  output logic [CNT_W-1:0] count_sel_o,
  output logic [POS_W-1:0] pos_o,
  output logic [POS_W-1:0] err_abs_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SETTLE,
    DONE
  } state_e;

  localparam int SC_W = $clog2(SETTLE_CYC) + 1;

  localparam logic [POS_W-1:0] POS_MAX = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] STEP_F  = POS_W'(STEP_FWD);
  localparam logic [POS_W-1:0] STEP_R  = POS_W'(STEP_REV);
  localparam logic [POS_W-1:0] TOL_V   = POS_W'(TOL);
  localparam logic [POS_W-1:0] EC1_V   = POS_W'(EC1);
  localparam logic [POS_W-1:0] EC2_V   = POS_W'(EC2);
  localparam logic [POS_W-1:0] EC3_V   = POS_W'(EC3);
  localparam logic [POS_W-1:0] EC4_V   = POS_W'(EC4);
  localparam logic [CNT_W-1:0] PL0_V   = CNT_W'(PL0);
  localparam logic [CNT_W-1:0] PL1_V   = CNT_W'(PL1);
  localparam logic [CNT_W-1:0] PL2_V   = CNT_W'(PL2);
  localparam logic [CNT_W-1:0] PL3_V   = CNT_W'(PL3);
  localparam logic [CNT_W-1:0] PL4_V   = CNT_W'(PL4);
  localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic             dirc_q, dirc_d;
  logic [POS_W-1:0] tgt_q, tgt_d;
  logic [SC_W-1:0]  settle_q, settle_d;
  logic             fresh_q, fresh_d;

  logic             sync1_q, sync2_q, sync3_q;
  logic             pulse_edge;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] err_abs_q, err_abs_d;
  logic [CNT_W-1:0] count_sel_q, count_sel_d;
  logic             want_fwd;
  logic             err_in_tol;

  // Pulse pin is asynchronous: two flops for metastability, a third to find the rising edge.
  always_ff @(posedge clk_50m_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= pulse_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign pulse_edge = sync2_q & ~sync3_q;

  // Position saturates at both ends; homing beats a simultaneous pulse.
  always_comb begin
    pos_d = pos_q;
    if (zero_pos_i) begin
      pos_d = '0;
    end else if (pulse_edge) begin
      if (dirc_q) begin
        pos_d = (pos_q > POS_MAX - STEP_F) ? POS_MAX : pos_q + STEP_F;
      end else begin
        pos_d = (pos_q < STEP_R) ? '0 : pos_q - STEP_R;
      end
    end
  end

  always_comb begin
    err_abs_d = (tgt_q >= pos_q) ? (tgt_q - pos_q) : (pos_q - tgt_q);
  end

  always_comb begin
    count_sel_d = PL0_V;
    if (err_abs_q > EC1_V) begin
      count_sel_d = PL4_V;
    end else if (err_abs_q > EC2_V) begin
      count_sel_d = PL3_V;
    end else if (err_abs_q > EC3_V) begin
      count_sel_d = PL2_V;
    end else if (err_abs_q > EC4_V) begin
      count_sel_d = PL1_V;
    end
  end

  always_ff @(posedge clk_50m_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q       <= '0;
      err_abs_q   <= '0;
      count_sel_q <= PL0_V;
    end else begin
      pos_q       <= pos_d;
      err_abs_q   <= err_abs_d;
      count_sel_q <= count_sel_d;
    end
  end

  assign want_fwd   = (tgt_q > pos_q);
  assign err_in_tol = (err_abs_q <= TOL_V);

  always_ff @(posedge clk_50m_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      en_q     <= 1'b1;
      dirc_q   <= 1'b0;
      tgt_q    <= '0;
      settle_q <= '0;
      fresh_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      dirc_q   <= dirc_d;
      tgt_q    <= tgt_d;
      settle_q <= settle_d;
      fresh_q  <= fresh_d;
    end
  end

  // fresh_q covers the first MOVE cycle, when err_abs still reflects the previous target.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    dirc_d   = dirc_q;
    tgt_d    = tgt_q;
    settle_d = settle_q;
    fresh_d  = 1'b0;

    case (state_q)
      IDLE: begin
        en_d = 1'b1;
        if (tgt_if.tgt_valid && !abort_i) begin
          tgt_d   = tgt_if.tgt_pos;
          fresh_d = 1'b1;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (fresh_q) begin
          en_d = 1'b1;
        end else if (err_in_tol) begin
          en_d     = 1'b1;
          settle_d = SETTLE_LOAD;
          state_d  = SETTLE;
        end else if (!en_q && (want_fwd != dirc_q)) begin
          en_d = 1'b1;
        end else begin
          en_d   = 1'b0;
          dirc_d = want_fwd;
        end
      end
      SETTLE: begin
        en_d = 1'b1;
        if (!err_in_tol) begin
          state_d = MOVE;
        end else if (settle_q == '0) begin
          state_d = DONE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      DONE: begin
        en_d    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        en_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (abort_i) begin
      state_d = IDLE;
      en_d    = 1'b1;
      fresh_d = 1'b0;
    end
  end

  assign tgt_if.tgt_ready = (state_q == IDLE) && !abort_i;
  assign en_o             = en_q;
  assign dirc_o           = dirc_q;
  assign count_sel_o      = count_sel_q;
  assign pos_o            = pos_q;
  assign err_abs_o        = err_abs_q;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);

endmodule

// File: tb/tb_axis_pos_ctrl.sv
// Bench for axis_pos_ctrl: a pulse-train plant reacting to en/dirc, with position and
// pulse-count expectations derived from the stepping/tolerance/tier rules.
module tb_axis_pos_ctrl;

  localparam int POS_W      = 24;
  localparam int CNT_W      = 21;
  localparam int STEP_FWD   = 256;
  localparam int STEP_REV   = 256;
  localparam int TOL        = 3840;
  localparam int EC1        = 786432;
  localparam int EC2        = 524288;
  localparam int EC3        = 262144;
  localparam int EC4        = 65536;
  localparam int PL0        = 250000;
  localparam int PL1        = 200000;
  localparam int PL2        = 150000;
  localparam int PL3        = 100000;
  localparam int PL4        = 50000;
  localparam int SETTLE_CYC = 1024;
  localparam int POS_MAX    = (1 << POS_W) - 1;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             pulse    = 1'b0;
  logic             abort    = 1'b0;
  logic             zero_pos = 1'b0;
  logic             en, dirc, busy, done;
  logic [CNT_W-1:0] count_sel;
  logic [POS_W-1:0] pos, err_abs;

  axis_pos_ctrl_if #(.POS_W(POS_W)) tgtIf ();

  axis_pos_ctrl dut (
    .clk_50m_i   (clk),
    .rst_ni      (rst_n),
    .pulse_i     (pulse),
    .abort_i     (abort),
    .zero_pos_i  (zero_pos),
    .tgt_if      (tgtIf),
    .en_o        (en),
    .dirc_o      (dirc),
    .count_sel_o (count_sel),
    .pos_o       (pos),
    .err_abs_o   (err_abs),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #10 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;
  int mPos      = 0;
  int mTgt      = 0;
  bit mDir      = 1'b0;

  function automatic int absDiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int stepPos(input int p, input bit fwd);
    if (fwd) return (p + STEP_FWD > POS_MAX) ? POS_MAX : p + STEP_FWD;
    return (p < STEP_REV) ? 0 : p - STEP_REV;
  endfunction

  function automatic int tier(input int e);
    int ecTab[4] = '{EC1, EC2, EC3, EC4};
    int plTab[4] = '{PL4, PL3, PL2, PL1};
    for (int i = 0; i < 4; i++) if (e > ecTab[i]) return plTab[i];
    return PL0;
  endfunction

  function automatic int pulsesToArrive(input int p, input int t, input bit fwd);
    int n = 0;
    while (absDiff(p, t) > TOL && n < 100000) begin
      p = stepPos(p, fwd);
      n++;
    end
    return n;
  endfunction

  function automatic int pulsesToLeave(input int p, input int t, input bit fwd);
    int n = 0;
    while (absDiff(p, t) <= TOL && n < 100000) begin
      p = stepPos(p, fwd);
      n++;
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendPulse();
    pulse = 1'b1;
    tick(2);
    pulse = 1'b0;
    tick(4);
    mPos = stepPos(mPos, mDir);
  endtask

  task automatic applyStimulus(input int tgt);
    tgtIf.tgt_pos   = POS_W'(tgt);
    tgtIf.tgt_valid = 1'b1;
    checkOutput("ready_idle", 32'(tgtIf.tgt_ready), 1);
    tick(1);
    tgtIf.tgt_valid = 1'b0;
    mTgt = tgt;
    checkOutput("busy_accept", 32'(busy), 1);
  endtask

  task automatic waitEnLow();
    int w = 0;
    while (en !== 1'b0 && w < 20) begin
      tick(1);
      w++;
    end
    checkOutput("en_drive", 32'(en), 0);
  endtask

  task automatic driveMove();
    int nExp;
    int n;
    int lowSeen;
    if (absDiff(mPos, mTgt) <= TOL) begin
      lowSeen = 0;
      for (int i = 0; i < 6; i++) begin
        if (en === 1'b0) lowSeen++;
        tick(1);
      end
      checkOutput("en_held_in_pos", lowSeen, 0);
    end else begin
      mDir = (mTgt > mPos);
      nExp = pulsesToArrive(mPos, mTgt, mDir);
      waitEnLow();
      checkOutput("dirc_move", 32'(dirc), 32'(mDir));
      checkOutput("count_sel_start", 32'(count_sel), tier(absDiff(mPos, mTgt)));
      n = 0;
      while (en === 1'b0 && n < nExp + 5) begin
        sendPulse();
        n++;
        checkOutput("err_abs_track", 32'(err_abs), absDiff(mPos, mTgt));
        checkOutput("count_sel_track", 32'(count_sel), tier(absDiff(mPos, mTgt)));
      end
      checkOutput("pulses_to_arrive", n, nExp);
      checkOutput("en_stop", 32'(en), 1);
      checkOutput("pos_arrive", 32'(pos), mPos);
    end
  endtask

  task automatic waitDone(output int cycles);
    bit seen  = 1'b0;
    int enLow = 0;
    cycles = 0;
    while (!seen && cycles < SETTLE_CYC + 40) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (en === 1'b0) enLow++;
        tick(1);
        cycles++;
      end
    end
    checkOutput("done_seen", 32'(seen), 1);
    checkOutput("en_high_settle", enLow, 0);
    checkOutput("busy_in_done", 32'(busy), 1);
    tick(1);
    checkOutput("done_single", 32'(done), 0);
    checkOutput("busy_idle", 32'(busy), 0);
    checkOutput("ready_after_done", 32'(tgtIf.tgt_ready), 1);
    checkOutput("pos_final", 32'(pos), mPos);
  endtask

  initial begin
    int n;
    int nExp;
    int cyc;
    int gapLen;
    int gapDir;
    int k;

    tgtIf.tgt_valid = 1'b0;
    tgtIf.tgt_pos   = '0;
    tick(3);
    checkOutput("rst_en", 32'(en), 1);
    checkOutput("rst_dirc", 32'(dirc), 0);
    checkOutput("rst_pos", 32'(pos), 0);
    checkOutput("rst_err", 32'(err_abs), 0);
    checkOutput("rst_count_sel", 32'(count_sel), PL0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_ready", 32'(tgtIf.tgt_ready), 1);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] forward move to 384000");
    applyStimulus(384000);
    driveMove();

    $display("[TB] coast overshoot during settle");
    nExp = pulsesToLeave(mPos, mTgt, mDir);
    n = 0;
    while (en === 1'b1 && busy === 1'b1 && n < nExp + 5) begin
      sendPulse();
      n++;
    end
    checkOutput("coast_pulses", n, nExp);
    checkOutput("coast_en_redrive", 32'(en), 0);
    checkOutput("coast_dirc", 32'(dirc), 32'(mTgt > mPos));
    driveMove();
    waitDone(cyc);

    $display("[TB] reverse move to 0");
    applyStimulus(0);
    driveMove();
    waitDone(cyc);

    $display("[TB] coasting pulses clamp at 0");
    for (int i = 0; i < 20; i++) sendPulse();
    checkOutput("clamp_zero", 32'(pos), mPos);
    checkOutput("clamp_model_zero", 32'(mPos), 0);
    checkOutput("coast_idle_en", 32'(en), 1);

    $display("[TB] direction change gap");
    applyStimulus(50000);
    driveMove();
    waitDone(cyc);
    checkOutput("settle_length", cyc, SETTLE_CYC - 1);
    applyStimulus(20000);
    mDir = 1'b0;
    waitEnLow();
    checkOutput("rev_dirc", 32'(dirc), 0);
    for (int i = 0; i < 5; i++) sendPulse();
    checkOutput("rev_pos", 32'(pos), mPos);
    zero_pos = 1'b1;
    tick(1);
    zero_pos = 1'b0;
    mPos = 0;
    checkOutput("zero_mid_move", 32'(pos), 0);
    gapLen = 0;
    gapDir = 0;
    k = 0;
    while (k < 10 && !(en === 1'b0 && dirc === 1'b1)) begin
      if (en === 1'b1) begin
        gapLen++;
        gapDir = gapDir + int'(dirc);
      end
      tick(1);
      k++;
    end
    checkOutput("gap_len", gapLen, 1);
    checkOutput("gap_old_dirc", gapDir, 0);
    checkOutput("gap_new_dirc", 32'(dirc), 1);
    driveMove();
    waitDone(cyc);

    $display("[TB] zero_pos coincident with pulse edge");
    mDir = 1'b1;
    pulse = 1'b1;
    tick(2);
    pulse = 1'b0;
    zero_pos = 1'b1;
    tick(1);
    zero_pos = 1'b0;
    tick(4);
    mPos = 0;
    checkOutput("zero_beats_pulse", 32'(pos), 0);

    $display("[TB] abort mid-move");
    applyStimulus(200000);
    mDir = 1'b1;
    waitEnLow();
    n = 0;
    while (mPos < 100000 && en === 1'b0 && n < 500) begin
      sendPulse();
      n++;
    end
    checkOutput("abort_prep_pos", 32'(pos), mPos);
    abort = 1'b1;
    tgtIf.tgt_pos   = POS_W'(5000);
    tgtIf.tgt_valid = 1'b1;
    tick(1);
    checkOutput("abort_en", 32'(en), 1);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    tick(1);
    checkOutput("abort_blocks_accept", 32'(busy), 0);
    abort = 1'b0;
    tgtIf.tgt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("abort_no_done", 32'(done), 0);
    end
    checkOutput("abort_idle", 32'(busy), 0);
    checkOutput("abort_target_kept", 32'(err_abs), absDiff(mPos, mTgt));

    $display("[TB] target equal to position");
    applyStimulus(mPos);
    driveMove();
    waitDone(cyc);

    $display("[TB] randomized moves");
    for (int r = 0; r < 6; r++) begin
      int t;
      t = mPos + int'($urandom_range(0, 24000)) - 12000;
      if (t < 0) t = 0;
      applyStimulus(t);
      driveMove();
      waitDone(cyc);
    end

    $display("[TB] reset mid-move");
    applyStimulus(mPos + 40000);
    mDir = 1'b1;
    waitEnLow();
    for (int i = 0; i < 3; i++) sendPulse();
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_en", 32'(en), 1);
    checkOutput("async_rst_dirc", 32'(dirc), 0);
    checkOutput("async_rst_pos", 32'(pos), 0);
    checkOutput("async_rst_err", 32'(err_abs), 0);
    checkOutput("async_rst_count_sel", 32'(count_sel), PL0);
    checkOutput("async_rst_busy", 32'(busy), 0);
    checkOutput("async_rst_done", 32'(done), 0);
    checkOutput("async_rst_ready", 32'(tgtIf.tgt_ready), 1);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      pulse = 1'b1;
      tick(2);
      pulse = 1'b0;
      tick(2);
    end
    rst_n = 1'b1;
    mPos = 0;
    mTgt = 0;
    tick(6);
    checkOutput("rst_pulses_ignored", 32'(pos), mPos);
    checkOutput("post_rst_en", 32'(en), 1);
    checkOutput("post_rst_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
